// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a multi-cycle data memory over req/ack, stalls upstream
// while an access is outstanding, steers byte/half lanes and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ExMem_Valid,
  input  logic [31:0] ALU_Result_In,
  input  logic [31:0] Store_Data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Mem_Size,
  input  logic        Mem_Unsigned,
  input  logic        MemtoReg_In,
  input  logic        RegWrite_In,
  input  logic [4:0]  Write_Reg_In,
  output logic        Dmem_Req,
  output logic        Dmem_We,
  output logic [31:0] Dmem_Addr,
  output logic [31:0] Dmem_Wdata,
  output logic [3:0]  Dmem_Be,
  input  logic        Dmem_Ack,
  input  logic [31:0] Dmem_Rdata,
  output logic        Mem_Stall,
  output logic        MemWb_Valid,
  output logic [31:0] Read_Data,
  output logic [31:0] ALU_Result,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [4:0]  Write_Reg,
  output logic        Misaligned,
  output logic        Bus_Error
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  ld_off_q, ld_off_d, ld_size_q, ld_size_d;
  logic        ld_uns_q, ld_uns_d;
  logic        valid_q, valid_d, m2r_q, m2r_d, rw_q, rw_d;
  logic [31:0] rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        mis_q, mis_d, berr_q, berr_d;

  logic        memop, aligned, tmo_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign memop   = ExMem_Valid & (MemRead | MemWrite);
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  // Stall drops combinationally on ack/timeout so EX/MEM advances on the same edge WB loads.
  assign Mem_Stall = (state_q == S_IDLE) ? (memop & aligned) : ~(Dmem_Ack | tmo_hit);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    aligned  = 1'b1;
    st_be    = 4'b1111;
    st_wdata = Store_Data;
    case (Mem_Size)
      2'b00: begin
        st_be    = 4'b0001 << ALU_Result_In[1:0];
        st_wdata = {4{Store_Data[7:0]}};
      end
      2'b01: begin
        aligned  = ~ALU_Result_In[0];
        st_be    = ALU_Result_In[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{Store_Data[15:0]}};
      end
      default: aligned = (ALU_Result_In[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    ld_byte = Dmem_Rdata[7:0];
    case (ld_off_q)
      2'd1:    ld_byte = Dmem_Rdata[15:8];
      2'd2:    ld_byte = Dmem_Rdata[23:16];
      2'd3:    ld_byte = Dmem_Rdata[31:24];
      default: ld_byte = Dmem_Rdata[7:0];
    endcase
    ld_half = ld_off_q[1] ? Dmem_Rdata[31:16] : Dmem_Rdata[15:0];
    case (ld_size_q)
      2'b00:   ld_ext = {{24{~ld_uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~ld_uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = Dmem_Rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ld_off_d  = ld_off_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    // MEM/WB defaults to a bubble; only completing instructions overwrite it.
    valid_d   = 1'b0;
    rdata_d   = '0;
    alu_d     = '0;
    m2r_d     = 1'b0;
    rw_d      = 1'b0;
    wreg_d    = '0;
    mis_d     = 1'b0;
    berr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memop && !aligned) begin
          mis_d = 1'b1;
        end else if (memop) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = MemWrite;
          addr_d    = {ALU_Result_In[31:2], 2'b00};
          wdata_d   = MemWrite ? st_wdata : '0;
          be_d      = MemWrite ? st_be : 4'b1111;
          ld_off_d  = ALU_Result_In[1:0];
          ld_size_d = Mem_Size;
          ld_uns_d  = Mem_Unsigned;
        end else begin
          valid_d = ExMem_Valid;
          alu_d   = ALU_Result_In;
          m2r_d   = MemtoReg_In;
          rw_d    = RegWrite_In & ExMem_Valid;
          wreg_d  = Write_Reg_In;
        end
      end
      S_WAIT: begin
        if (Dmem_Ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          rdata_d = we_q ? '0 : ld_ext;
          alu_d   = ALU_Result_In;
          m2r_d   = MemtoReg_In;
          rw_d    = RegWrite_In;
          wreg_d  = Write_Reg_In;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      ld_off_q  <= '0;
      ld_size_q <= '0;
      ld_uns_q  <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      alu_q     <= '0;
      m2r_q     <= 1'b0;
      rw_q      <= 1'b0;
      wreg_q    <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      ld_off_q  <= ld_off_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
      alu_q     <= alu_d;
      m2r_q     <= m2r_d;
      rw_q      <= rw_d;
      wreg_q    <= wreg_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign Dmem_Req    = req_q;
  assign Dmem_We     = we_q;
  assign Dmem_Addr   = addr_q;
  assign Dmem_Wdata  = wdata_q;
  assign Dmem_Be     = be_q;
  assign MemWb_Valid = valid_q;
  assign Read_Data   = rdata_q;
  assign ALU_Result  = alu_q;
  assign MemtoReg    = m2r_q;
  assign RegWrite    = rw_q;
  assign Write_Reg   = wreg_q;
  assign Misaligned  = mis_q;
  assign Bus_Error   = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random instructions, each checked
// against a transaction-level model of the expected memory request and MEM/WB contents.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ExMem_Valid, MemRead, MemWrite, Mem_Unsigned, MemtoReg_In, RegWrite_In;
  logic [31:0] ALU_Result_In, Store_Data, Dmem_Rdata;
  logic [1:0]  Mem_Size;
  logic [4:0]  Write_Reg_In;
  logic        Dmem_Ack;
  logic        Dmem_Req, Dmem_We, Mem_Stall, MemWb_Valid, MemtoReg, RegWrite, Misaligned, Bus_Error;
  logic [31:0] Dmem_Addr, Dmem_Wdata, Read_Data, ALU_Result;
  logic [3:0]  Dmem_Be;
  logic [4:0]  Write_Reg;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ExMem_Valid(ExMem_Valid), .ALU_Result_In(ALU_Result_In),
    .Store_Data(Store_Data), .MemRead(MemRead), .MemWrite(MemWrite), .Mem_Size(Mem_Size),
    .Mem_Unsigned(Mem_Unsigned), .MemtoReg_In(MemtoReg_In), .RegWrite_In(RegWrite_In),
    .Write_Reg_In(Write_Reg_In), .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr),
    .Dmem_Wdata(Dmem_Wdata), .Dmem_Be(Dmem_Be), .Dmem_Ack(Dmem_Ack), .Dmem_Rdata(Dmem_Rdata),
    .Mem_Stall(Mem_Stall), .MemWb_Valid(MemWb_Valid), .Read_Data(Read_Data),
    .ALU_Result(ALU_Result), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Write_Reg(Write_Reg),
    .Misaligned(Misaligned), .Bus_Error(Bus_Error)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic        m2r;
    logic        rw;
    logic [4:0]  wreg;
    logic        mis;
    logic        berr;
  } wb_t;

  wb_t         exp_wb;
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_cnt, req_cnt;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_wb();
    check("wb_valid", MemWb_Valid, exp_wb.valid);
    check("wb_rdata", Read_Data, exp_wb.rdata);
    check("wb_alu", ALU_Result, exp_wb.alu);
    check("wb_m2r", MemtoReg, exp_wb.m2r);
    check("wb_rw", RegWrite, exp_wb.rw);
    check("wb_wreg", Write_Reg, exp_wb.wreg);
    check("misaligned", Misaligned, exp_wb.mis);
    check("bus_error", Bus_Error, exp_wb.berr);
  endtask

  task automatic check_all_zero(input string tag);
    exp_wb = '0;
    check_wb();
    check({tag, "_req"}, Dmem_Req, 0);
    check({tag, "_we"}, Dmem_We, 0);
    check({tag, "_addr"}, Dmem_Addr, 0);
    check({tag, "_wdata"}, Dmem_Wdata, 0);
    check({tag, "_be"}, Dmem_Be, 0);
  endtask

  function automatic logic is_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b1;
    if (sz == 2'b01) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'b00) return 4'(1 << off);
    if (sz == 2'b01) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    v = rd >> (8 * int'(a % 4));
    if (sz == 2'b00) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic drive(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, sd, input logic m2r, rw, input logic [4:0] wr_reg);
    ExMem_Valid = v; MemRead = rd; MemWrite = wr; Mem_Size = sz; Mem_Unsigned = uns;
    ALU_Result_In = a; Store_Data = sd; MemtoReg_In = m2r; RegWrite_In = rw; Write_Reg_In = wr_reg;
  endtask

  // One instruction through MEM; ack_wait = WAIT cycles without ack before the ack
  // (ack_wait >= TMO means the memory never answers).
  task automatic do_op(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, sd, input logic m2r, rw, input logic [4:0] wr_reg,
                       input int ack_wait, input logic [31:0] rdata);
    logic memop, al, ack, tmo;
    @(negedge clk);
    drive(v, rd, wr, sz, uns, a, sd, m2r, rw, wr_reg);
    Dmem_Ack   = ($urandom_range(0, 3) != 0);
    Dmem_Rdata = $urandom;
    #1;
    check_wb();
    last_rd = Read_Data;
    check("req_idle", Dmem_Req, 0);
    memop = v & (rd | wr);
    al    = is_aligned(sz, a);
    check("stall_idle", Mem_Stall, memop & al);
    stall_cnt = int'(Mem_Stall);
    req_cnt   = 0;
    exp_wb    = '0;
    if (!memop) begin
      exp_wb.valid = v;
      exp_wb.alu   = a;
      exp_wb.m2r   = m2r;
      exp_wb.rw    = rw & v;
      exp_wb.wreg  = wr_reg;
    end else if (!al) begin
      exp_wb.mis = 1'b1;
    end else begin
      for (int k = 0; k < TMO; k++) begin
        @(negedge clk);
        ack        = (k == ack_wait);
        Dmem_Ack   = ack;
        Dmem_Rdata = ack ? rdata : $urandom;
        #1;
        req_cnt   += int'(Dmem_Req);
        stall_cnt += int'(Mem_Stall);
        check("wait_req", Dmem_Req, 1);
        check("wait_addr", Dmem_Addr, a & 32'hFFFF_FFFC);
        check("wait_we", Dmem_We, wr);
        check("wait_be", Dmem_Be, wr ? exp_be(sz, a) : 4'hF);
        if (wr) check("wait_wdata", Dmem_Wdata, exp_wdata(sz, sd));
        check("wait_wb_bubble", MemWb_Valid, 0);
        tmo = !ack && (k == TMO - 1);
        check("wait_stall", Mem_Stall, !(ack || tmo));
        if (ack) begin
          exp_wb.valid = 1'b1;
          exp_wb.rdata = wr ? 32'h0 : exp_load(rdata, a, sz, uns);
          exp_wb.alu   = a;
          exp_wb.m2r   = m2r;
          exp_wb.rw    = rw;
          exp_wb.wreg  = wr_reg;
          break;
        end
        if (tmo) begin
          exp_wb.berr = 1'b1;
          break;
        end
      end
    end
  endtask

  initial begin
    logic        v, rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    int          kind;

    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    Dmem_Ack = 1'b0; Dmem_Rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    check("reset_stall", Mem_Stall, 0);
    rst_n = 1'b1;

    // lb / lbu at 0x103, ack on the first WAIT cycle
    do_op(1, 1, 0, 2'b00, 0, 32'h103, 0, 1, 1, 5'd3, 0, 32'h80FF7F01);
    check("lb_stall_cycles", stall_cnt, 1);
    do_op(1, 1, 0, 2'b00, 1, 32'h103, 0, 1, 1, 5'd4, 0, 32'h80FF7F01);
    check("lb_read_data", last_rd, 32'hFFFF_FF80);
    // sh at 0x202, ack after three idle WAIT cycles
    do_op(1, 0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 0, 0, 5'd0, 3, 32'h0);
    check("lbu_read_data", last_rd, 32'h0000_0080);
    check("sh_bubbles", stall_cnt, 4);
    // misaligned lw
    do_op(1, 1, 0, 2'b10, 0, 32'h206, 0, 1, 1, 5'd7, 0, 32'h0);
    // timeout, then ack on the last allowed cycle
    do_op(1, 1, 0, 2'b10, 0, 32'h300, 0, 1, 1, 5'd8, 100, 32'h0);
    check("tmo_req_cycles", req_cnt, TMO);
    do_op(1, 1, 0, 2'b10, 0, 32'h304, 0, 1, 1, 5'd9, TMO - 1, 32'hCAFEF00D);
    check("late_ack_req_cycles", req_cnt, TMO);
    // lw then add back-to-back, spurious acks while idle
    do_op(1, 1, 0, 2'b10, 0, 32'h400, 0, 1, 1, 5'd10, 0, 32'h1357_9BDF);
    do_op(1, 0, 0, 2'b10, 0, 32'hDEADBEEF, 0, 0, 1, 5'd11, 0, 32'h0);
    do_op(0, 0, 0, 2'b00, 0, 32'h55, 0, 0, 1, 5'd12, 0, 32'h0);

    // reset while an access is outstanding
    @(negedge clk);
    drive(1, 1, 0, 2'b10, 0, 32'h500, 0, 1, 1, 5'd13);
    Dmem_Ack = 1'b0;
    #1;
    check_wb();
    check("rst_pre_stall", Mem_Stall, 1);
    @(negedge clk);
    #1;
    check("rst_pre_req", Dmem_Req, 1);
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rst_req_next", Dmem_Req, 0);
    @(negedge clk);
    #1;
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    do_op(1, 0, 0, 2'b00, 0, 32'h0000_1234, 0, 0, 1, 5'd14, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 2));
      v    = ($urandom_range(0, 7) != 0);
      wr   = (kind == 2);
      rd   = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
        else if (sz != 2'b00) a = a & 32'hFFFF_FFFC;
      end
      do_op(v, rd, wr, sz, uns, a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), $urandom);
    end
    do_op(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
